// File: rtl/cnn_pkg.sv
// cnn_pkg: sequencer state encoding, default sizes and the watchdog error byte
package cnn_pkg;
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, ARGMAX, TX, WAIT_TX, ERR} state_t;
    localparam int DEF_DATA_W = 18;
    localparam int DEF_N_CLASS = 16;
    localparam logic [7:0] ERR_BYTE = 8'hFF;
endpackage

// File: rtl/cnn_seq_ctrl_if.sv
// cnn_seq_ctrl_if: host, layer, dense-readout and UART signals of the sequencer.
//   strt in host start | tx_done UART complete | l_rdy/l_strt per-layer handshake
//   res_idx/res_din dense readout | bsy busy | trmt/dout UART request | err watchdog
//   master = environment side, slave = sequencer side
interface cnn_seq_ctrl_if #(
    parameter int N_LAYERS = 5,
    parameter int N_CLASS = cnn_pkg::DEF_N_CLASS,
    parameter int DATA_W = cnn_pkg::DEF_DATA_W
);
    logic strt, tx_done, bsy, trmt, err;
    logic [N_LAYERS-1:0] l_rdy, l_strt;
    logic [$clog2(N_CLASS)-1:0] res_idx;
    logic signed [DATA_W-1:0] res_din;
    logic [7:0] dout;
    modport master(output strt, tx_done, l_rdy, res_din, input l_strt, res_idx, bsy, trmt, dout, err);
    modport slave(input strt, tx_done, l_rdy, res_din, output l_strt, res_idx, bsy, trmt, dout, err);
endinterface

// File: rtl/cnn_argmax.sv
// cnn_argmax: serial signed max-with-index tracker; idx==0 loads unconditionally, ties keep the lower index.
//   clk, rst_n | clr zero the tracker | en sample val/idx | best_val, best_idx result
module cnn_argmax
    import cnn_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IW = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] val,
    input  logic [IW-1:0]            idx,
    output logic signed [DATA_W-1:0] best_val,
    output logic [IW-1:0]            best_idx
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            best_val <= '0;
            best_idx <= '0;
        end else if (clr) begin
            best_val <= '0;
            best_idx <= '0;
        end else if (en && (idx == '0 || val > best_val)) begin
            best_val <= val;
            best_idx <= idx;
        end
endmodule

// File: rtl/cnn_seq_ctrl.sv
// cnn_seq_ctrl: CNN layer sequencer, serial argmax of the dense outputs and UART result handoff.
//   clk, rst_n (async active-low) | bus: cnn_seq_ctrl_if.slave (strt, tx_done, l_rdy, l_strt,
//   res_idx, res_din, bsy, trmt, dout, err). Optional CNN_SEQ_WDOG_EN adds a per-layer watchdog.
module cnn_seq_ctrl
    import cnn_pkg::*;
#(
    parameter int N_LAYERS = 5,
    parameter int N_CLASS = DEF_N_CLASS,
    parameter int DATA_W = DEF_DATA_W
`ifdef CNN_SEQ_WDOG_EN
    , parameter int WDOG_CYC = 2**20
`endif
) (
    input logic clk,
    input logic rst_n,
    cnn_seq_ctrl_if.slave bus
);
    localparam int LW = $clog2(N_LAYERS);
    localparam int IW = $clog2(N_CLASS);
    state_t state, nxt;
    logic [LW-1:0] layer, layer_nxt;
    logic [IW-1:0] idx, idx_nxt, best_idx;
    logic signed [DATA_W-1:0] unused_best_val;
    logic [7:0] dout_q;
    logic bsy_q, err_q, timeout;
    always_comb begin
        nxt = state;
        layer_nxt = layer;
        idx_nxt = idx;
        case (state)
            IDLE: if (bus.strt) begin
                nxt = LAUNCH;
                layer_nxt = '0;
            end
            LAUNCH: nxt = WAIT;
            WAIT: if (bus.l_rdy[layer]) begin
                nxt = layer == LW'(N_LAYERS - 1) ? ARGMAX : LAUNCH;
                layer_nxt = layer == LW'(N_LAYERS - 1) ? layer : layer + 1'b1;
            end else if (timeout) nxt = ERR;
            ARGMAX: begin
                nxt = idx == IW'(N_CLASS - 1) ? TX : ARGMAX;
                idx_nxt = idx == IW'(N_CLASS - 1) ? '0 : idx + 1'b1;
            end
            TX: nxt = WAIT_TX;
            WAIT_TX: if (bus.tx_done) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            layer <= '0;
            idx <= '0;
            dout_q <= '0;
            bsy_q <= 1'b0;
        end else begin
            state <= nxt;
            layer <= layer_nxt;
            idx <= idx_nxt;
            dout_q <= bus.dout;
            bsy_q <= nxt != IDLE && nxt != ERR;
        end
    cnn_argmax #(.DATA_W(DATA_W), .IW(IW)) u_argmax (
        .clk(clk),
        .rst_n(rst_n),
        .clr(state == IDLE && bus.strt),
        .en(state == ARGMAX),
        .val(bus.res_din),
        .idx(idx),
        .best_val(unused_best_val),
        .best_idx(best_idx)
    );
    // dout is live in TX/ERR and otherwise replays the byte captured from itself
    assign bus.dout = state == TX ? 8'(best_idx) : state == ERR ? ERR_BYTE : dout_q;
    assign bus.l_strt = state == LAUNCH ? N_LAYERS'(1) << layer : '0;
    assign bus.res_idx = idx;
    assign bus.trmt = state == TX || state == ERR;
    assign bus.bsy = bsy_q;
    assign bus.err = err_q;
`ifdef CNN_SEQ_WDOG_EN
    localparam int CW = $clog2(WDOG_CYC);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt <= '0;
            err_q <= 1'b0;
        end else begin
            cnt <= state == LAUNCH ? '0 : state == WAIT ? cnt + 1'b1 : cnt;
            err_q <= nxt == ERR ? 1'b1 : state == IDLE && bus.strt ? 1'b0 : err_q;
        end
    // ERR is entered exactly WDOG_CYC clocks after the layer's l_strt cycle
    assign timeout = cnt == CW'(WDOG_CYC - 2);
`else
    assign timeout = 1'b0;
    assign err_q = 1'b0;
`endif
endmodule

// File: tb/tb_cnn_seq_ctrl.sv
// tb_cnn_seq_ctrl: randomized scoreboard bench for cnn_seq_ctrl with layer/UART models and an argmax reference.
module tb_cnn_seq_ctrl;
    logic clk = 0, rst_n;
    always #5 clk = ~clk;
    cnn_seq_ctrl_if #(.N_LAYERS(5), .N_CLASS(16), .DATA_W(18)) bus();
    cnn_seq_ctrl #(
        .N_LAYERS(5), .N_CLASS(16), .DATA_W(18)
`ifdef CNN_SEQ_WDOG_EN
        , .WDOG_CYC(64)
`endif
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic signed [17:0] vals [16];
    assign bus.res_din = vals[bus.res_idx];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int exp_layer[$], exp_dout[$];
    int vectors = 0, miscmp = 0, n_tx = 0, tmo = 0;
    int rdy_cyc = -100, txd_cyc = -100, lst_cyc = -100;
    int dly_fix = 0;
    bit spur = 0, hang = 0, fin = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int ref_argmax();
        int b = 0;
        for (int k = 1; k < 16; k++) if (vals[k] > vals[b]) b = k;
        return b;
    endfunction

    // layer and UART models; drive on the falling edge
    initial begin
        int cur, lcnt, tcnt;
        cur = 0; lcnt = 0; tcnt = 0;
        bus.l_rdy = '0; bus.tx_done = 0;
        forever begin
            @(negedge clk);
            bus.l_rdy = '0; bus.tx_done = 0;
            if (!rst_n) begin
                lcnt = 0; tcnt = 0;
                continue;
            end
            if (bus.l_strt != 0) begin
                for (int i = 0; i < 5; i++) if (bus.l_strt[i]) cur = i;
                lcnt = (hang && cur == 2) ? 0 : dly_fix != 0 ? dly_fix : int'($urandom_range(12, 1));
                if (spur) bus.l_rdy[cur] = 1;
            end else if (lcnt > 0) begin
                lcnt--;
                if (lcnt == 0) begin
                    bus.l_rdy[cur] = 1;
                    rdy_cyc = cyc;
                end else if (spur && cur == 1 && lcnt == 4) begin
                    bus.l_rdy[3] = 1;
                    bus.tx_done = 1;
                end
            end
            if (bus.trmt) tcnt = $urandom_range(5, 1);
            else if (tcnt > 0) begin
                tcnt--;
                if (tcnt == 0) begin
                    bus.tx_done = 1;
                    txd_cyc = cyc;
                end
            end
        end
    end

    // monitor: pops the scoreboard whenever the DUT presents l_strt or trmt
    initial begin
        int el, ed, held;
        bit p_go, p_trmt;
        p_go = 0; p_trmt = 0; held = 0;
        forever begin
            @(negedge clk);
            if (fin) begin
                check("timeouts", tmo, 0);
                check("drain", exp_layer.size() + exp_dout.size(), 0);
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
                $finish;
            end
            if (!rst_n) begin
                check("rst_out", {bus.l_strt, bus.res_idx, bus.bsy, bus.trmt, bus.dout, bus.err}, 0);
                p_go = 0; p_trmt = 0; held = 0;
                continue;
            end
            if (bus.l_strt != 0 || p_go) begin
                el = exp_layer.size() != 0 ? exp_layer.pop_front() : -1;
                check("l_strt", bus.l_strt, el < 0 ? 0 : 1 << el);
                if (el == 0) check("strt_lat", p_go, 1);
                if (el > 0) check("rdy_gap", cyc - rdy_cyc, 1);
                lst_cyc = cyc;
            end
            if (p_trmt) check("trmt_once", bus.trmt, 0);
            if (bus.trmt) begin
                n_tx++;
                ed = exp_dout.size() != 0 ? exp_dout.pop_front() : -1;
                check("dout", bus.dout, ed);
                check("err", bus.err, ed == 255);
                check("bsy_tx", bus.bsy, ed != 255);
                check("tx_lat", ed == 255 ? cyc - lst_cyc : cyc - rdy_cyc, ed == 255 ? 64 : 17);
                held = ed;
            end
            if (cyc == txd_cyc + 1) begin
                check("bsy_fall", bus.bsy, 0);
                check("dout_hold", bus.dout, held);
            end
            p_go = !bus.bsy && bus.strt && !bus.trmt;
            p_trmt = bus.trmt;
        end
    end

    task automatic go(input int nl, input int e);
        for (int i = 0; i < nl; i++) exp_layer.push_back(i);
        exp_dout.push_back(e);
        @(posedge clk); #1 bus.strt = 1;
        @(posedge clk); #1 bus.strt = 0;
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 1000 && n_tx < n; i++) @(negedge clk);
        if (n_tx < n) begin
            tmo++;
            $display("FAIL wait_tx: got %0d transmits, required %0d", n_tx, n);
        end
        for (int i = 0; i < 50 && bus.bsy; i++) @(negedge clk);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int t;
        rst_n = 0; bus.strt = 0;
        for (int k = 0; k < 16; k++) vals[k] = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        for (int k = 0; k < 16; k++) vals[k] = 18'(k * 100);
        dly_fix = 10; t = n_tx;
        go(5, 15); wait_tx(t + 1);
        for (int k = 0; k < 16; k++) vals[k] = 18'(-5);
        vals[3] = 18'sh1F; vals[9] = 18'sh1F;
        dly_fix = 0; t = n_tx;
        go(5, 3); wait_tx(t + 1);
        for (int k = 0; k < 16; k++) vals[k] = 18'($urandom);
        spur = 1; dly_fix = 8; t = n_tx;
        go(5, ref_argmax());
        repeat (5) @(posedge clk);
        #1 bus.strt = 1;
        repeat (3) @(posedge clk);
        #1 bus.strt = 0;
        wait_tx(t + 1);
        spur = 0; dly_fix = 0;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 16; k++) vals[k] = r[0] ? 18'($urandom_range(6, 0) - 3) : 18'($urandom);
            t = n_tx;
            go(5, ref_argmax()); wait_tx(t + 1);
        end
        for (int k = 0; k < 16; k++) vals[k] = 18'($urandom);
        go(5, ref_argmax());
        for (int i = 0; i < 1000 && bus.res_idx != 5; i++) @(negedge clk);
        @(posedge clk); #2 rst_n = 0;
        exp_dout.delete(); exp_layer.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        for (int k = 0; k < 16; k++) vals[k] = 18'(1000 - k * 10);
        t = n_tx;
        go(5, 0); wait_tx(t + 1);
        for (int k = 0; k < 16; k++) vals[k] = '0;
        vals[7] = 18'sd1000;
        t = n_tx;
        for (int i = 0; i < 5; i++) exp_layer.push_back(i);
        exp_dout.push_back(7);
        @(posedge clk); #1 bus.strt = 1;
        for (int i = 0; i < 1000 && n_tx < t + 1; i++) @(negedge clk);
        for (int k = 0; k < 16; k++) vals[k] = 18'(-1);
        vals[12] = 18'sd50;
        for (int i = 0; i < 5; i++) exp_layer.push_back(i);
        exp_dout.push_back(12);
        for (int i = 0; i < 1000 && n_tx < t + 2; i++) @(negedge clk);
        @(posedge clk); #1 bus.strt = 0;
        wait_tx(t + 2);
`ifdef CNN_SEQ_WDOG_EN
        hang = 1; t = n_tx;
        go(3, 255); wait_tx(t + 1);
        hang = 0; t = n_tx;
        for (int k = 0; k < 16; k++) vals[k] = 18'($urandom);
        go(5, ref_argmax()); wait_tx(t + 1);
`endif
        fin = 1;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: cycle %0d, required finish before 200000", cyc);
        $fatal(1);
    end
endmodule
